xadc_sensor_tracker: RTL and testbench

- Consumes the four raw XADC sensor words (temperature, VCCINT, VCCAUX, VCCBRAM) produced by the DRP polling stage.
- Snapshots the four words at a fixed rate and keeps per-channel latest, minimum, maximum and exponential-average values.
- Drives a debounced over-temperature warning with hysteresis.
- Exposes all tracked values through a simple request/acknowledge readout port for the slow-control register bank.

---
 rtl/xadc_sensor_tracker.sv | 189 ++++++++++++++++++
 tb/tb_xadc_sensor_tracker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_sensor_tracker.sv
// XADC sensor tracker: periodic snapshot of temperature and supply words, with per-channel
// latest/min/max/EMA tracking, a debounced over-temperature warning and a req/ack readout port.
module xadc_sensor_tracker #(
  parameter int unsigned SAMPLE_DIV = 1000000,
  parameter int unsigned AVG_SHIFT  = 4,
  parameter int unsigned PERSIST    = 3,
  parameter logic [11:0] TEMP_HI    = 12'hB5E,
  parameter logic [11:0] TEMP_LO    = 12'h9A3
) (
  input  logic        dclk,
  input  logic        reset,
  input  logic [15:0] measured_temp,
  input  logic [15:0] measured_vccint,
  input  logic [15:0] measured_vccaux,
  input  logic [15:0] measured_vccbram,
  input  logic        clear_minmax,
  input  logic        rd_req,
  input  logic [3:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  output logic [31:0] sample_count,
  output logic        temp_warn
);

  localparam int unsigned ACC_W = 12 + AVG_SHIFT;
  localparam int unsigned PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  // Update states carry the channel number in their low bits.
  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] SNAP = 3'b001;
  localparam logic [2:0] DONE = 3'b010;
  localparam logic [2:0] UPD0 = 3'b100;
  localparam logic [2:0] UPD1 = 3'b101;
  localparam logic [2:0] UPD2 = 3'b110;
  localparam logic [2:0] UPD3 = 3'b111;

  logic [PW-1:0]    presc_q;
  logic             tick;
  logic [2:0]       state_q, state_d;
  logic             seedFlag_q, seedNow_q;
  logic [11:0]      latest_q [4];
  logic [11:0]      min_q [4];
  logic [11:0]      max_q [4];
  logic [ACC_W-1:0] acc_q [4];
  logic [31:0]      sampleCount_q;
  logic             tempWarn_q;
  logic [3:0]       persist_q;
  logic [15:0]      rdData_q;
  logic             rdAck_q;

  logic [1:0]       updCh;
  logic             isUpd;
  logic [11:0]      updCode, updMin_d, updMax_d;
  logic [ACC_W-1:0] updAcc_d;
  logic             warnHit;
  logic [11:0]      rdVal;
  logic             unusedNibbles;

  assign unusedNibbles = ^{measured_temp[3:0], measured_vccint[3:0],
                           measured_vccaux[3:0], measured_vccbram[3:0]};

  assign tick = (presc_q == DIV_LAST);

  always_ff @(posedge dclk) begin
    if (reset || tick) presc_q <= '0;
    else               presc_q <= presc_q + PW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SNAP;
      SNAP:    state_d = UPD0;
      UPD0:    state_d = UPD1;
      UPD1:    state_d = UPD2;
      UPD2:    state_d = UPD3;
      UPD3:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A clear arriving in the SNAP cycle must survive for the following snapshot.
  always_ff @(posedge dclk) begin
    if (reset) begin
      seedFlag_q <= 1'b1;
      seedNow_q  <= 1'b0;
    end else begin
      if (clear_minmax)         seedFlag_q <= 1'b1;
      else if (state_q == SNAP) seedFlag_q <= 1'b0;
      if (state_q == SNAP)      seedNow_q  <= seedFlag_q;
    end
  end

  assign isUpd = state_q[2];
  assign updCh = state_q[1:0];

  always_comb begin
    updCode = latest_q[updCh];
    if (seedNow_q) begin
      updMin_d = updCode;
      updMax_d = updCode;
      updAcc_d = {updCode, {AVG_SHIFT{1'b0}}};
    end else begin
      updMin_d = (updCode < min_q[updCh]) ? updCode : min_q[updCh];
      updMax_d = (updCode > max_q[updCh]) ? updCode : max_q[updCh];
      updAcc_d = acc_q[updCh] - (acc_q[updCh] >> AVG_SHIFT) + ACC_W'(updCode);
    end
  end

  always_ff @(posedge dclk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        latest_q[i] <= '0;
        min_q[i]    <= '0;
        max_q[i]    <= '0;
        acc_q[i]    <= '0;
      end
    end else begin
      if (state_q == SNAP) begin
        latest_q[0] <= measured_temp[15:4];
        latest_q[1] <= measured_vccint[15:4];
        latest_q[2] <= measured_vccaux[15:4];
        latest_q[3] <= measured_vccbram[15:4];
      end
      if (isUpd) begin
        min_q[updCh] <= updMin_d;
        max_q[updCh] <= updMax_d;
        acc_q[updCh] <= updAcc_d;
      end
    end
  end

  // One counter serves both directions since only one is active for a given warn level.
  assign warnHit = tempWarn_q ? (latest_q[0] <= TEMP_LO) : (latest_q[0] >= TEMP_HI);

  always_ff @(posedge dclk) begin
    if (reset) begin
      sampleCount_q <= '0;
      tempWarn_q    <= 1'b0;
      persist_q     <= '0;
    end else if (state_q == DONE) begin
      sampleCount_q <= sampleCount_q + 32'd1;
      if (warnHit) begin
        if (persist_q + 4'd1 == PERSIST_C) begin
          tempWarn_q <= ~tempWarn_q;
          persist_q  <= '0;
        end else begin
          persist_q <= persist_q + 4'd1;
        end
      end else begin
        persist_q <= '0;
      end
    end
  end

  always_comb begin
    rdVal = latest_q[rd_sel[3:2]];
    case (rd_sel[1:0])
      2'd1:    rdVal = min_q[rd_sel[3:2]];
      2'd2:    rdVal = max_q[rd_sel[3:2]];
      2'd3:    rdVal = acc_q[rd_sel[3:2]][ACC_W-1:AVG_SHIFT];
      default: rdVal = latest_q[rd_sel[3:2]];
    endcase
  end

  always_ff @(posedge dclk) begin
    if (reset) begin
      rdAck_q  <= 1'b0;
      rdData_q <= '0;
    end else begin
      rdAck_q <= rd_req;
      if (rd_req) rdData_q <= {4'h0, rdVal};
    end
  end

  assign rd_data      = rdData_q;
  assign rd_ack       = rdAck_q;
  assign sample_count = sampleCount_q;
  assign temp_warn    = tempWarn_q;

endmodule

// File: tb/tb_xadc_sensor_tracker.sv
// Bench for xadc_sensor_tracker: directed scenarios plus randomized traffic, compared every
// cycle against a snapshot-level model of the tracker.
module tb_xadc_sensor_tracker;

  localparam int SAMPLE_DIV = 16;
  localparam int AVG_SHIFT  = 4;
  localparam int PERSIST    = 3;
  localparam logic [11:0] TEMP_HI = 12'hB5E;
  localparam logic [11:0] TEMP_LO = 12'h9A3;

  logic        dclk;
  logic        reset;
  logic [15:0] measuredTemp, measuredVccint, measuredVccaux, measuredVccbram;
  logic        clearMinmax;
  logic        rdReq;
  logic [3:0]  rdSel;
  logic [15:0] rdData;
  logic        rdAck;
  logic [31:0] sampleCount;
  logic        tempWarn;

  int checks = 0;
  int errors = 0;

  xadc_sensor_tracker #(
    .SAMPLE_DIV(SAMPLE_DIV), .AVG_SHIFT(AVG_SHIFT), .PERSIST(PERSIST),
    .TEMP_HI(TEMP_HI), .TEMP_LO(TEMP_LO)
  ) dut (
    .dclk(dclk), .reset(reset),
    .measured_temp(measuredTemp), .measured_vccint(measuredVccint),
    .measured_vccaux(measuredVccaux), .measured_vccbram(measuredVccbram),
    .clear_minmax(clearMinmax), .rd_req(rdReq), .rd_sel(rdSel),
    .rd_data(rdData), .rd_ack(rdAck), .sample_count(sampleCount), .temp_warn(tempWarn)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  // Model state: values indexed channel*4+kind, with the pre-snapshot copy kept for reads that
  // land while the update sweep is still running.
  int          k = 0;
  bit          modelLive = 1'b0;
  int unsigned mCount;
  bit          mWarn;
  int          mCnt;
  bit          mFlag;
  bit          mExpAck;
  logic [15:0] mDataA, mDataB;
  logic [11:0] curVal [16];
  logic [11:0] prevVal [16];
  int unsigned mAcc [4];
  int          m;
  bit          seedNow;
  logic [11:0] codes [4];
  logic [11:0] c, mn, mx;

  initial begin
    forever begin
      @(posedge dclk);
      if (reset) begin
        k = 0; mCount = 0; mWarn = 0; mCnt = 0; mFlag = 1; mExpAck = 0;
        mDataA = '0; mDataB = '0;
        for (int i = 0; i < 16; i++) begin curVal[i] = '0; prevVal[i] = '0; end
        for (int i = 0; i < 4; i++) mAcc[i] = 0;
      end else begin
        k++;
        if (rdReq) begin
          m = k - 1;
          mExpAck = 1;
          mDataB = {4'h0, curVal[rdSel]};
          if (m >= 17 && (m % 16) >= 1 && (m % 16) <= 4) mDataA = {4'h0, prevVal[rdSel]};
          else mDataA = mDataB;
        end else begin
          mExpAck = 0;
        end
        if (k >= 17 && (k % 16) == 1) begin
          seedNow = mFlag;
          mFlag = clearMinmax;
          codes[0] = measuredTemp[15:4];   codes[1] = measuredVccint[15:4];
          codes[2] = measuredVccaux[15:4]; codes[3] = measuredVccbram[15:4];
          for (int i = 0; i < 16; i++) prevVal[i] = curVal[i];
          for (int ch = 0; ch < 4; ch++) begin
            c = codes[ch];
            if (seedNow) begin
              mn = c; mx = c;
              mAcc[ch] = c * (1 << AVG_SHIFT);
            end else begin
              mn = (c < curVal[ch*4+1]) ? c : curVal[ch*4+1];
              mx = (c > curVal[ch*4+2]) ? c : curVal[ch*4+2];
              mAcc[ch] = mAcc[ch] - mAcc[ch] / (1 << AVG_SHIFT) + c;
            end
            curVal[ch*4]   = c;
            curVal[ch*4+1] = mn;
            curVal[ch*4+2] = mx;
            curVal[ch*4+3] = 12'(mAcc[ch] / (1 << AVG_SHIFT));
          end
        end else begin
          mFlag = mFlag | clearMinmax;
        end
        if (k >= 22 && (k % 16) == 6) begin
          mCount++;
          if (!mWarn) begin
            mCnt = (curVal[0] >= TEMP_HI) ? mCnt + 1 : 0;
            if (mCnt == PERSIST) begin mWarn = 1; mCnt = 0; end
          end else begin
            mCnt = (curVal[0] <= TEMP_LO) ? mCnt + 1 : 0;
            if (mCnt == PERSIST) begin mWarn = 0; mCnt = 0; end
          end
        end
      end
      modelLive = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  initial begin
    forever begin
      @(negedge dclk);
      if (modelLive) begin
        checkOutput("sample_count", sampleCount, mCount);
        checkOutput("temp_warn", 32'(tempWarn), 32'(mWarn));
        checkOutput("rd_ack", 32'(rdAck), 32'(mExpAck));
        checks++;
        if (rdData !== mDataA && rdData !== mDataB) begin
          errors++;
          $display("[TB] FAIL rd_data actual=%h expected=%h or %h", rdData, mDataA, mDataB);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] t, input logic [15:0] vi,
                               input logic [15:0] va, input logic [15:0] vb);
    measuredTemp = t; measuredVccint = vi; measuredVccaux = va; measuredVccbram = vb;
  endtask

  task automatic waitK(input int target);
    int n = 0;
    while (k != target && n < 200) begin @(negedge dclk); n++; end
    if (k != target) begin
      checks++; errors++;
      $display("[TB] FAIL waitK timeout actual=%0d expected=%0d", k, target);
    end
  endtask

  task automatic waitPhase(input int ph);
    int n = 0;
    do begin @(negedge dclk); n++; end while (!(k >= 16 && (k % 16) == ph) && n < 100);
    if (!(k >= 16 && (k % 16) == ph)) begin
      checks++; errors++;
      $display("[TB] FAIL waitPhase timeout actual=%0d expected=%0d", k % 16, ph);
    end
  endtask

  // Issues n back-to-back requests (selects packed 4 bits each, first in the LSBs).
  task automatic readBurst(input int n, input logic [15:0] sels, output logic [63:0] got);
    got = '0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        got[(i-1)*16 +: 16] = rdData;
        checkOutput("ackPulse", 32'(rdAck), 32'd1);
      end
      if (i < n) begin rdReq = 1'b1; rdSel = sels[i*4 +: 4]; end
      else rdReq = 1'b0;
      @(negedge dclk);
    end
    checkOutput("ackEnd", 32'(rdAck), 32'd0);
  endtask

  function automatic logic [15:0] randTemp();
    logic [11:0] code;
    code = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(12'h990, 12'hB70));
    return {code, 4'($urandom)};
  endfunction

  logic [63:0] got;
  logic [15:0] tempSeq [10] = '{16'hB600, 16'hB600, 16'hA000, 16'hB600, 16'hB600,
                                16'hB600, 16'hA000, 16'h9900, 16'h9900, 16'h9900};
  logic [15:0] auxSeq [4] = '{16'h4000, 16'h8000, 16'h6000, 16'h6000};
  bit          warnSeq [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    reset = 1'b1; clearMinmax = 1'b0; rdReq = 1'b0; rdSel = '0;
    applyStimulus(16'hA000, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge dclk);
    reset = 1'b0;

    readBurst(1, 16'h0000, got);
    checkOutput("preSnapRead", 32'(got[15:0]), 32'h0);
    waitK(22);
    checkOutput("firstCount", sampleCount, 32'd1);
    readBurst(4, 16'h3210, got);
    checkOutput("tempLatest", 32'(got[15:0]),  32'h0A00);
    checkOutput("tempMin",    32'(got[31:16]), 32'h0A00);
    checkOutput("tempMax",    32'(got[47:32]), 32'h0A00);
    checkOutput("tempAvg",    32'(got[63:48]), 32'h0A00);

    applyStimulus(16'hA000, 16'h5000, 16'h0000, 16'h3000);
    clearMinmax = 1'b1; @(negedge dclk); clearMinmax = 1'b0;
    waitPhase(7);
    applyStimulus(16'hA000, 16'h5800, 16'h0000, 16'h3000);
    waitPhase(7);
    readBurst(4, 16'h7654, got);
    checkOutput("vccintLatest", 32'(got[15:0]),  32'h0580);
    checkOutput("vccintMin",    32'(got[31:16]), 32'h0500);
    checkOutput("vccintMax",    32'(got[47:32]), 32'h0580);
    checkOutput("vccintAvg",    32'(got[63:48]), 32'h0508);
    readBurst(3, 16'h0F50, got);
    checkOutput("burstTemp",   32'(got[15:0]),  32'h0A00);
    checkOutput("burstVccint", 32'(got[31:16]), 32'h0500);
    checkOutput("burstBram",   32'(got[47:32]), 32'h0300);
    checkOutput("countAt3", sampleCount, 32'd3);

    waitPhase(7);
    for (int s = 0; s < 10; s++) begin
      applyStimulus(tempSeq[s], 16'h5800, (s < 4) ? auxSeq[s] : 16'h6000, 16'h3000);
      if (s == 0) begin clearMinmax = 1'b1; @(negedge dclk); clearMinmax = 1'b0; end
      if (s == 2) begin
        waitPhase(2);
        clearMinmax = 1'b1; @(negedge dclk); clearMinmax = 1'b0;
      end
      waitPhase(7);
      checkOutput("warnSeq", 32'(tempWarn), 32'(warnSeq[s]));
      checkOutput("countSeq", sampleCount, 32'(5 + s));
      if (s == 2) begin
        readBurst(2, 16'h00A9, got);
        checkOutput("auxMinKept", 32'(got[15:0]),  32'h0400);
        checkOutput("auxMaxKept", 32'(got[31:16]), 32'h0800);
      end
      if (s == 3) begin
        readBurst(3, 16'h0BA9, got);
        checkOutput("auxMinSeed", 32'(got[15:0]),  32'h0600);
        checkOutput("auxMaxSeed", 32'(got[31:16]), 32'h0600);
        checkOutput("auxAvgSeed", 32'(got[47:32]), 32'h0600);
      end
    end

    for (int s = 0; s < 3; s++) begin
      applyStimulus(16'hB600, 16'h5800, 16'h6000, 16'h3000);
      waitPhase(7);
    end
    checkOutput("warnHigh", 32'(tempWarn), 32'd1);
    readBurst(1, 16'h0000, got);
    checkOutput("hotLatest", 32'(got[15:0]), 32'h0B60);
    applyStimulus(16'h7000, 16'h5800, 16'h6000, 16'h3000);
    waitPhase(3);
    reset = 1'b1; rdReq = 1'b1; rdSel = 4'h1;
    @(negedge dclk);
    checkOutput("rstAck",   32'(rdAck), 32'd0);
    checkOutput("rstData",  32'(rdData), 32'd0);
    checkOutput("rstCount", sampleCount, 32'd0);
    checkOutput("rstWarn",  32'(tempWarn), 32'd0);
    reset = 1'b0; rdReq = 1'b0;
    waitK(21);
    checkOutput("noTickYet", sampleCount, 32'd0);
    @(negedge dclk);
    checkOutput("tickAfterRst", sampleCount, 32'd1);
    readBurst(1, 16'h0001, got);
    checkOutput("reseedMin", 32'(got[15:0]), 32'h0700);

    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge dclk);
      reset = ($urandom_range(0, 299) == 0);
      clearMinmax = ($urandom_range(0, 39) == 0);
      rdReq = ($urandom_range(0, 1) == 1);
      rdSel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        applyStimulus(randTemp(), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    @(negedge dclk);
    reset = 1'b0; rdReq = 1'b0; clearMinmax = 1'b0;
    repeat (4) @(negedge dclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
